user_reg_initiator: RTL

// - Host-side master for the user-logic register and interrupt interfaces. Sits between the PCIe

---
 rtl/user_reg_pkg.sv | 24 ++
 rtl/user_intr_fwd.sv | 56 +++++
 rtl/user_reg_initiator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/user_reg_pkg.sv
// Shared definitions for the user register initiator: default widths,
// the read-timeout fill value and the two FSM state encodings.
package user_reg_pkg;

  localparam int          ADDR_W_DEF       = 20;
  localparam int          DATA_W_DEF       = 32;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } reg_state_t;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_SEND = 2'd1,
    I_ACK  = 2'd2,
    I_LOW  = 2'd3
  } intr_state_t;

endpackage

// File: rtl/user_intr_fwd.sv
// Interrupt forwarder: turns the user's level interrupt request into one
// MSI request towards the PCIe core, returns a one-cycle acknowledge to the
// user, and refuses to fire again until the user request has dropped.
module user_intr_fwd
  import user_reg_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_intr_req,
  output logic o_intr_ack,
  output logic o_host_intr_req,
  input  logic i_host_intr_ack
);

  intr_state_t state;

  // Interrupt FSM with registered request/acknowledge outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= I_IDLE;
      o_intr_ack      <= 1'b0;
      o_host_intr_req <= 1'b0;
    end else begin
      o_intr_ack <= 1'b0;
      case (state)
        I_IDLE: begin
          if (i_intr_req) begin
            state           <= I_SEND;
            o_host_intr_req <= 1'b1;
          end
        end
        I_SEND: begin
          if (i_host_intr_ack) begin
            state           <= I_ACK;
            o_host_intr_req <= 1'b0;
            o_intr_ack      <= 1'b1;
          end
        end
        I_ACK: begin
          state <= I_LOW;
        end
        I_LOW: begin
          // a held request must fall before it can raise another MSI
          if (!i_intr_req) begin
            state <= I_IDLE;
          end
        end
        default: begin
          state           <= I_IDLE;
          o_host_intr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/user_reg_initiator.sv
// Host-side master for the user-logic register and interrupt interfaces.
// Converts host register strobes into single-cycle user wr/rd requests and
// returns read data with a completion strobe.
// Optional feature: define USER_REG_TIMEOUT_EN to bound the read-ack wait;
// an expired wait completes with TIMEOUT_DATA and o_host_rd_err=1.
//
// Host handshake: i_host_wr_req / i_host_rd_req are single-cycle strobes that
// are accepted only while o_host_busy is low; strobes seen while busy are
// dropped without effect, and a simultaneous write+read accepts the write.
// A read completes with exactly one o_host_rd_valid cycle carrying
// o_host_rd_data and o_host_rd_err.
module user_reg_initiator
  import user_reg_pkg::*;
#(
  parameter int                ADDR_W         = ADDR_W_DEF,
  parameter int                DATA_W         = DATA_W_DEF,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = DATA_W'(TIMEOUT_DATA_DEF)
) (
  input  logic              i_pcie_clk,
  input  logic              i_rst_n,
  input  logic              i_host_wr_req,
  input  logic              i_host_rd_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wr_data,
  output logic              o_host_busy,
  output logic              o_host_rd_valid,
  output logic [DATA_W-1:0] o_host_rd_data,
  output logic              o_host_rd_err,
  output logic [ADDR_W-1:0] o_user_addr,
  output logic [DATA_W-1:0] o_user_data,
  output logic              o_user_wr_req,
  output logic              o_user_rd_req,
  input  logic [DATA_W-1:0] i_user_data,
  input  logic              i_user_rd_ack,
  input  logic              i_intr_req,
  output logic              o_intr_ack,
  output logic              o_host_intr_req,
  input  logic              i_host_intr_ack
);

  reg_state_t state;

`ifdef USER_REG_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] to_cnt_nxt;

  assign to_cnt_nxt = to_cnt + 1'b1;
`else
  // timeout parameters are only consumed by the timeout build
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (^TIMEOUT_DATA) ^ (TIMEOUT_CYCLES > 0);
  assign o_host_rd_err      = 1'b0;
`endif

  assign o_host_busy = (state != IDLE);

  // Register FSM: accept host strobes in IDLE, issue one-cycle user requests,
  // wait for the read acknowledge and present the completion for one cycle
  always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_user_addr     <= '0;
      o_user_data     <= '0;
      o_user_wr_req   <= 1'b0;
      o_user_rd_req   <= 1'b0;
      o_host_rd_valid <= 1'b0;
      o_host_rd_data  <= '0;
`ifdef USER_REG_TIMEOUT_EN
      o_host_rd_err   <= 1'b0;
      to_cnt          <= '0;
`endif
    end else begin
      o_user_wr_req   <= 1'b0;
      o_user_rd_req   <= 1'b0;
      o_host_rd_valid <= 1'b0;
`ifdef USER_REG_TIMEOUT_EN
      o_host_rd_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_host_wr_req) begin
            state         <= WR;
            o_user_addr   <= i_host_addr;
            o_user_data   <= i_host_wr_data;
            o_user_wr_req <= 1'b1;
          end else if (i_host_rd_req) begin
            state         <= RD_REQ;
            o_user_addr   <= i_host_addr;
            o_user_rd_req <= 1'b1;
          end
        end
        WR: begin
          state <= IDLE;
        end
        RD_REQ: begin
          // an ack coinciding with the request cycle is deliberately ignored
          state <= RD_WAIT;
`ifdef USER_REG_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        RD_WAIT: begin
`ifdef USER_REG_TIMEOUT_EN
          to_cnt <= to_cnt_nxt;
`endif
          if (i_user_rd_ack) begin
            state           <= RD_DONE;
            o_host_rd_data  <= i_user_data;
            o_host_rd_valid <= 1'b1;
          end
`ifdef USER_REG_TIMEOUT_EN
          else if (to_cnt_nxt == CNT_TERM) begin
            state           <= RD_DONE;
            o_host_rd_data  <= TIMEOUT_DATA;
            o_host_rd_err   <= 1'b1;
            o_host_rd_valid <= 1'b1;
          end
`endif
        end
        RD_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  user_intr_fwd u_intr_fwd (
    .i_clk           (i_pcie_clk),
    .i_rst_n         (i_rst_n),
    .i_intr_req      (i_intr_req),
    .o_intr_ack      (o_intr_ack),
    .o_host_intr_req (o_host_intr_req),
    .i_host_intr_ack (i_host_intr_ack)
  );

endmodule
